// File: rtl/shot_pos_receiver.sv
// Receive side of the inter-board shot-position link: reassembles tagged 5-bit words
// into a validated (x, y) pair that only ever updates atomically.
module shot_pos_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 650,
  parameter int unsigned STALE_CYCLES   = 65_000_000,
  parameter int unsigned X_MAX          = 1023,
  parameter int unsigned Y_MAX          = 767
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [9:0] shot_xpos,
  output logic [9:0] shot_ypos,
  output logic       pos_valid,
  output logic       frame_err,
  output logic       link_ok
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned ST_W = $clog2(STALE_CYCLES) + 1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STALE_CYCLES);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STALE_CYCLES - 1);

  localparam logic [2:0] TAG_XL = 3'b001;
  localparam logic [2:0] TAG_XH = 3'b010;
  localparam logic [2:0] TAG_YL = 3'b101;
  localparam logic [2:0] TAG_YH = 3'b110;

  typedef enum logic [1:0] {
    WAIT_XL,
    WAIT_XH,
    WAIT_YL,
    WAIT_YH
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      xl_q, xh_q, yl_q;
  logic [4:0]      xl_d, xh_d, yl_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [ST_W-1:0] stale_cnt_q;
  logic            load_c;
  logic            err_c;
  logic [9:0]      x_c;
  logic [9:0]      y_c;
  logic [2:0]      tag_c;
  logic [4:0]      payload_c;

  assign tag_c     = rx_data[2:0];
  assign payload_c = rx_data[7:3];
  assign x_c       = {xh_q, xl_q};
  assign y_c       = {payload_c, yl_q};

  // Next-state, shadow capture and completion/error decode
  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xh_d    = xh_q;
    yl_d    = yl_q;
    load_c  = 1'b0;
    err_c   = 1'b0;
    if (rx_valid) begin
      if (tag_c == TAG_XL) begin
        // An x-low word always (re)starts a frame, from any state.
        xl_d    = payload_c;
        state_d = WAIT_XH;
      end else begin
        case (state_q)
          WAIT_XL: ;
          WAIT_XH: begin
            if (tag_c == TAG_XH) begin
              xh_d    = payload_c;
              state_d = WAIT_YL;
            end else begin
              err_c   = 1'b1;
              state_d = WAIT_XL;
            end
          end
          WAIT_YL: begin
            if (tag_c == TAG_YL) begin
              yl_d    = payload_c;
              state_d = WAIT_YH;
            end else begin
              err_c   = 1'b1;
              state_d = WAIT_XL;
            end
          end
          WAIT_YH: begin
            state_d = WAIT_XL;
            if (tag_c == TAG_YH &&
                {1'b0, x_c} <= 11'(X_MAX) &&
                {1'b0, y_c} <= 11'(Y_MAX)) begin
              load_c = 1'b1;
            end else begin
              err_c = 1'b1;
            end
          end
          default: state_d = WAIT_XL;
        endcase
      end
    end else if (state_q != WAIT_XL && to_cnt_q == TO_LAST) begin
      err_c   = 1'b1;
      state_d = WAIT_XL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_XL;
      xl_q        <= '0;
      xh_q        <= '0;
      yl_q        <= '0;
      to_cnt_q    <= '0;
      stale_cnt_q <= '0;
      shot_xpos   <= '0;
      shot_ypos   <= '0;
      pos_valid   <= 1'b0;
      frame_err   <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      state_q   <= state_d;
      xl_q      <= xl_d;
      xh_q      <= xh_d;
      yl_q      <= yl_d;
      pos_valid <= load_c;
      frame_err <= err_c;
      if (load_c) begin
        shot_xpos <= x_c;
        shot_ypos <= y_c;
      end
      // Idle timer only runs while a frame is partially received
      if (rx_valid || state_q == WAIT_XL || err_c) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      // Link-health timer; positions are deliberately kept when it expires
      if (load_c) begin
        stale_cnt_q <= '0;
        link_ok     <= 1'b1;
      end else if (stale_cnt_q != ST_MAX) begin
        stale_cnt_q <= stale_cnt_q + ST_W'(1);
        if (stale_cnt_q == ST_LAST) begin
          link_ok <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shot_pos_receiver.sv
// Scoreboard bench for shot_pos_receiver: a word-level frame model predicts every
// pos_valid/frame_err event (with its cycle) and the held position / link state.
module tb_shot_pos_receiver;

  localparam int unsigned T = 650;
  localparam int unsigned S = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] shot_xpos, shot_ypos;
  logic       pos_valid, frame_err, link_ok;

  shot_pos_receiver #(
    .TIMEOUT_CYCLES(T),
    .STALE_CYCLES  (S),
    .X_MAX         (1023),
    .Y_MAX         (767)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .shot_xpos(shot_xpos),
    .shot_ypos(shot_ypos),
    .pos_valid(pos_valid),
    .frame_err(frame_err),
    .link_ok  (link_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [9:0] x;
    logic [9:0] y;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input bit ok, input string name, input string info);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  // Word-level reference: position in frame 0..3, expected tag per position
  int         m_idx  = 0;
  int         m_last = 0;
  int         m_exp_tag[4] = '{1, 2, 5, 6};
  logic [4:0] m_xl, m_xh, m_yl;

  task automatic push_ev(input bit e, input int x, input int y, input int c);
    ev_t ev;
    ev.is_err = e;
    ev.x      = 10'(x);
    ev.y      = 10'(y);
    ev.cyc    = c;
    exp_q.push_back(ev);
  endtask

  task automatic model_gap(input int n_new);
    if (m_idx != 0 && n_new - m_last - 1 >= int'(T)) begin
      push_ev(1'b1, 0, 0, m_last + 1 + int'(T));
      m_idx = 0;
    end
  endtask

  task automatic model_word(input logic [7:0] d, input int n);
    int         tag;
    logic [4:0] p;
    int         x, y;
    tag    = int'(d[2:0]);
    p      = d[7:3];
    m_last = n;
    if (tag == 1) begin
      m_xl  = p;
      m_idx = 1;
    end else if (m_idx == 0) begin
      // mid-stream join: ignored
    end else if (tag == m_exp_tag[m_idx]) begin
      if (m_idx == 1) begin
        m_xh  = p;
        m_idx = 2;
      end else if (m_idx == 2) begin
        m_yl  = p;
        m_idx = 3;
      end else begin
        x = int'(m_xh) * 32 + int'(m_xl);
        y = int'(p) * 32 + int'(m_yl);
        push_ev(!(x <= 1023 && y <= 767), x, y, n + 1);
        m_idx = 0;
      end
    end else begin
      push_ev(1'b1, 0, 0, n + 1);
      m_idx = 0;
    end
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int n_new;
    n_new = cyc + gap + 1;
    model_gap(n_new);
    model_word(d, n_new);
    repeat (gap) idle_cyc();
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = d;
  endtask

  task automatic drain(input int k);
    model_gap(cyc + k + 1);
    repeat (k) idle_cyc();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rst      = 1'b0;
    m_idx    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 80) return int'($urandom_range(0, 3));
    if (r < 97) return int'($urandom_range(4, 120));
    if (r == 97) return int'(T) - 1;
    if (r == 98) return int'(T);
    return int'(T) + 3;
  endfunction

  // Monitor: pops expected events and checks the held pair / link every cycle
  bit         have_good = 1'b0;
  int         good_cyc  = 0;
  logic [9:0] ex = '0;
  logic [9:0] ey = '0;
  ev_t        mon_e;
  bit         exp_link;

  always @(negedge clk) begin
    if (!rst) begin
      have_good = 1'b0;
      ex = '0;
      ey = '0;
      check(shot_xpos == 0 && shot_ypos == 0 && !pos_valid && !frame_err && !link_ok, "reset_state",
            $sformatf("got x=%0d y=%0d pv=%0b fe=%0b lk=%0b, want all 0",
                      shot_xpos, shot_ypos, pos_valid, frame_err, link_ok));
    end else begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check(exp_q[0].cyc >= cyc, "missing_event",
              $sformatf("no output at cycle %0d, want err=%0b", exp_q[0].cyc, exp_q[0].is_err));
        void'(exp_q.pop_front());
      end
      if (pos_valid || frame_err) begin
        check(!(pos_valid && frame_err), "exclusive", $sformatf("pv=%0b fe=%0b both high at %0d",
              pos_valid, frame_err, cyc));
        check(exp_q.size() != 0, "event_expected",
              $sformatf("got pv=%0b fe=%0b at %0d, want none", pos_valid, frame_err, cyc));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check(pos_valid == !mon_e.is_err && frame_err == mon_e.is_err && cyc == mon_e.cyc, "event",
                $sformatf("got pv=%0b fe=%0b at %0d, want err=%0b at %0d",
                          pos_valid, frame_err, cyc, mon_e.is_err, mon_e.cyc));
          if (!mon_e.is_err) begin
            ex        = mon_e.x;
            ey        = mon_e.y;
            have_good = 1'b1;
            good_cyc  = mon_e.cyc;
          end
        end
      end
      exp_link = have_good && (cyc - good_cyc) < int'(S);
      check(shot_xpos == ex && shot_ypos == ey && link_ok == exp_link, "hold",
            $sformatf("cyc %0d got x=%0d y=%0d lk=%0b, want x=%0d y=%0d lk=%0b",
                      cyc, shot_xpos, shot_ypos, link_ok, ex, ey, exp_link));
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] xv, yv;
    logic [7:0] w[4];
    int         r, nw;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: nominal frame, words 3 cycles apart
    send(8'h61, 2); send(8'h4A, 2); send(8'h45, 2); send(8'h36, 2);
    drain(5);
    // 2: y out of range keeps old pair
    send(8'h61, 2); send(8'h4A, 2); send(8'h05, 2); send(8'hCE, 2);
    drain(5);
    // 3: inter-word timeout, then a good frame
    send(8'h61, 0); send(8'h4A, 0);
    drain(int'(T) + 10);
    send(8'h61, 0); send(8'h4A, 0); send(8'h45, 0); send(8'h36, 0);
    drain(5);
    // 4: join mid-stream, then resync
    do_reset();
    send(8'h4A, 1); send(8'h36, 1);
    drain(5);
    send(8'h61, 0); send(8'h61, 0); send(8'h4A, 0); send(8'h45, 0); send(8'h36, 0);
    drain(5);
    // 5: skipped tag, then stale link
    send(8'h61, 1); send(8'h45, 1);
    drain(5);
    send(8'h61, 0); send(8'h4A, 0); send(8'h45, 0); send(8'h36, 0);
    drain(int'(S) + 10);
    // 6: reset mid-frame, then a full frame
    send(8'h61, 1); send(8'h4A, 1);
    do_reset();
    send(8'h45, 1); send(8'h36, 1);
    send(8'h61, 1); send(8'h4A, 1); send(8'h45, 1); send(8'h36, 1);
    drain(5);

    // Randomized frames with corruption and boundary gaps
    for (int f = 0; f < 300; f++) begin
      xv = 10'($urandom_range(0, 1023));
      yv = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(768, 1023)) : 10'($urandom_range(0, 767));
      w[0] = {xv[4:0], 3'b001};
      w[1] = {xv[9:5], 3'b010};
      w[2] = {yv[4:0], 3'b101};
      w[3] = {yv[9:5], 3'b110};
      r  = int'($urandom_range(0, 19));
      nw = 4;
      if (r == 0) begin
        w[1] = w[2]; w[2] = w[3]; nw = 3;
      end else if (r == 1) begin
        case ($urandom_range(0, 3))
          0: w[2][2:0] = 3'b000;
          1: w[2][2:0] = 3'b011;
          2: w[2][2:0] = 3'b100;
          default: w[2][2:0] = 3'b111;
        endcase
      end else if (r == 2) begin
        send(8'($urandom_range(0, 255)), pick_gap());
      end
      for (int i = 0; i < nw; i++) send(w[i], pick_gap());
    end

    drain(int'(T) + 20);
    check(exp_q.size() == 0, "queue_empty", $sformatf("%0d events never seen, want 0", exp_q.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
